// File: rtl/imem_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_refill_ctrl_pkg
// Shared definitions for the instruction-memory refill engine: the refill FSM
// state encoding and the default burst length. Word and address widths come
// from the project-wide `MEMORY_WORD / `PC_SIZE macros; fallback values are
// provided here so the slice also elaborates on its own.
// -----------------------------------------------------------------------------
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package imem_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    DONE    = 3'd4
  } refill_state_t;

  localparam int LINE_WORDS_DEFAULT = 16;

endpackage

// File: rtl/imem_refill_ctrl_word_counter.sv
// -----------------------------------------------------------------------------
// refill_word_counter
// Index of the word currently being fetched within a refill line.
// Ports:
//   clk, nrst  - clock, asynchronous active-low reset
//   clear      - restart the line at word 0 (wins over incr)
//   incr       - advance to the next word
//   count      - current word index
//   last       - high when count addresses the final word of the line
// -----------------------------------------------------------------------------
module refill_word_counter
  import imem_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/imem_refill_ctrl.sv
// -----------------------------------------------------------------------------
// imem_refill_ctrl
// Refill engine between the instruction-cache miss interface and a synchronous
// instruction SRAM. On a miss it reads LINE_WORDS consecutive words starting at
// the latched base address, one read at a time, and hands each word back to
// the core as a registered mem_word with a single-cycle word_ready pulse.
// Ports:
//   clk, nrst    - clock, asynchronous active-low reset
//   i_miss       - refill request, held high for the whole line
//   ram_address  - line base word address, sampled when a refill starts
//   word_ready   - one-cycle pulse, mem_word valid
//   mem_word     - returned instruction word (registered, holds between pulses)
//   refill_busy  - high while the engine is not idle
//   mem_rd_en    - SRAM read strobe, one cycle per word
//   mem_addr     - SRAM word address
//   mem_rdata    - SRAM read data, valid MEM_LATENCY cycles after mem_rd_en
// -----------------------------------------------------------------------------
module imem_refill_ctrl
  import imem_refill_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH  = `MEMORY_WORD,
  parameter int ADDR_WIDTH  = `PC_SIZE,
  parameter int LINE_WORDS  = LINE_WORDS_DEFAULT,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  word_ready,
  output logic [WORD_WIDTH-1:0] mem_word,
  output logic                  refill_busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int LAT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  refill_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  word_ready_q, word_ready_d;
  logic [WORD_WIDTH-1:0] mem_word_q, mem_word_d;

  logic                  cnt_clear;
  logic                  cnt_incr;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_last;

  refill_word_counter #(
    .LINE_WORDS (LINE_WORDS),
    .CNT_W      (CNT_W)
  ) u_word_counter (
    .clk   (clk),
    .nrst  (nrst),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .count (cnt),
    .last  (cnt_last)
  );

  // Dropping i_miss in ISSUE/WAIT/DELIVER abandons the line; the word counter
  // is cleared so a later miss always starts from word 0. Read data still in
  // flight in the SRAM pipeline is simply never captured.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    lat_d        = lat_q;
    word_ready_d = 1'b0;
    mem_word_d   = mem_word_q;
    cnt_clear    = 1'b0;
    cnt_incr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_miss) begin
          base_d    = ram_address;
          cnt_clear = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!i_miss) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_miss) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (lat_q == '0) begin
          // SRAM data is valid in this cycle; capture it for DELIVER.
          mem_word_d   = mem_rdata;
          word_ready_d = 1'b1;
          state_d      = DELIVER;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DELIVER: begin
        if (!i_miss) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_incr = 1'b1;
          state_d  = ISSUE;
        end
      end
      DONE: begin
        // Wait for the core to release the request before accepting another.
        if (!i_miss) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      lat_q        <= '0;
      word_ready_q <= 1'b0;
      mem_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      lat_q        <= lat_d;
      word_ready_q <= word_ready_d;
      mem_word_q   <= mem_word_d;
    end
  end

  // SRAM strobe and address are decoded from the state register only, so an
  // asynchronous reset clears them immediately. The address add wraps
  // naturally at ADDR_WIDTH bits.
  assign mem_rd_en   = (state_q == ISSUE);
  assign mem_addr    = (state_q == ISSUE) ? (base_q + ADDR_WIDTH'(cnt)) : '0;
  assign refill_busy = (state_q != IDLE);
  assign word_ready  = word_ready_q;
  assign mem_word    = mem_word_q;

endmodule
